// File: rtl/st7735_pkg.sv
// Shared command codes, decoder states and constants for the ST7735 SPI receiver.
package st7735_pkg;

    localparam logic [7:0] CMD_CASET  = 8'h2A;
    localparam logic [7:0] CMD_RASET  = 8'h2B;
    localparam logic [7:0] CMD_RAMWR  = 8'h2C;

    localparam int SYNC_DEPTH = 2;

    typedef enum logic [2:0] {
        IDLE,
        CASET,
        RASET,
        RAMWR,
        IGNORE
    } dec_state_t;

endpackage

// File: rtl/st7735_spi_rx_byte_rx.sv
// SPI mode-0 slave byte receiver: input synchronisers, sclk edge detect,
// MSB-first shifter and partial-byte abort on chip-select release.
module spi_byte_rx
    import st7735_pkg::*;
(
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       lcd_cs,
    input  logic       lcd_dc,
    input  logic       lcd_sclk,
    input  logic       lcd_mosi,
    output logic [8:0] rx_data,
    output logic       rx_valid,
    output logic       err_abort
);

    logic [SYNC_DEPTH-1:0] r_cs_sync;
    logic [SYNC_DEPTH-1:0] r_dc_sync;
    logic [SYNC_DEPTH-1:0] r_sclk_sync;
    logic [SYNC_DEPTH-1:0] r_mosi_sync;
    logic                  r_sclk_d;
    logic                  r_cs_d;
    logic [2:0]            r_bit_cnt;
    logic [6:0]            r_shift;
    logic [8:0]            r_word_p0;
    logic                  r_vld_p0;

    logic w_cs, w_dc, w_sclk, w_mosi;
    logic w_sclk_rise, w_cs_rise, w_sample, w_last;

    assign w_cs        = r_cs_sync[SYNC_DEPTH-1];
    assign w_dc        = r_dc_sync[SYNC_DEPTH-1];
    assign w_sclk      = r_sclk_sync[SYNC_DEPTH-1];
    assign w_mosi      = r_mosi_sync[SYNC_DEPTH-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_cs_rise   = w_cs & ~r_cs_d;
    // A final edge arriving together with cs release still completes the byte.
    assign w_sample    = w_sclk_rise & (~w_cs | (w_cs_rise & (r_bit_cnt == 3'd7)));
    assign w_last      = w_sample & (r_bit_cnt == 3'd7);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cs_sync   <= '1;
            r_dc_sync   <= '0;
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_DEPTH-2:0], lcd_cs};
            r_dc_sync   <= {r_dc_sync[SYNC_DEPTH-2:0], lcd_dc};
            r_sclk_sync <= {r_sclk_sync[SYNC_DEPTH-2:0], lcd_sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_DEPTH-2:0], lcd_mosi};
            r_sclk_d    <= w_sclk;
            r_cs_d      <= w_cs;
        end
    end

    // Stage p0: shift / byte completion / abort
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_bit_cnt <= 3'd0;
            r_shift   <= 7'd0;
            r_word_p0 <= 9'd0;
            r_vld_p0  <= 1'b0;
            err_abort <= 1'b0;
        end else begin
            r_vld_p0  <= 1'b0;
            err_abort <= 1'b0;
            if (w_sample) begin
                r_shift   <= {r_shift[5:0], w_mosi};
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (w_last) begin
                    r_vld_p0  <= 1'b1;
                    r_word_p0 <= {w_dc, r_shift, w_mosi};
                end
            end else if (w_cs) begin
                r_bit_cnt <= 3'd0;
                if (r_bit_cnt != 3'd0) begin
                    err_abort <= 1'b1;
                end
            end
        end
    end

    // Stage p1: registered byte output
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_data  <= 9'd0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= r_vld_p0;
            if (r_vld_p0) begin
                rx_data <= r_word_p0;
            end
        end
    end

endmodule

// File: rtl/st7735_spi_rx.sv
// ST7735 display-side receiver: byte deserialiser plus CASET/RASET/RAMWR decoder
// producing RGB565 pixels with window-relative x/y coordinates.
module st7735_spi_rx
    import st7735_pkg::*;
#(
    parameter int WIDTH   = 128,
    parameter int HEIGHT  = 160,
    parameter int COORD_W = 8
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               lcd_cs,
    input  logic               lcd_dc,
    input  logic               lcd_sclk,
    input  logic               lcd_mosi,
    output logic [8:0]         rx_data,
    output logic               rx_valid,
    output logic               cmd_valid,
    output logic [7:0]         cmd_code,
    output logic               pix_valid,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [15:0]        pix_rgb,
    output logic               frame_start,
    output logic               err_abort
);

    localparam logic [COORD_W-1:0] XE_RST = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0] YE_RST = COORD_W'(HEIGHT - 1);
    localparam logic [COORD_W-1:0] ALL1   = '1;

    logic [8:0]         w_rx_data;
    logic               w_rx_valid;
    logic               w_err_abort;
    logic               w_dc;
    logic [7:0]         w_byte;
    logic               w_x_wrap, w_y_wrap;
    logic [COORD_W-1:0] w_end;

    dec_state_t         r_state, w_state_next;
    logic [2:0]         r_pidx;
    logic [COORD_W-1:0] r_p_start, r_p_end;
    logic [COORD_W-1:0] r_xs, r_xe, r_ys, r_ye, r_x, r_y;
    logic [7:0]         r_hi;
    logic               r_hi_vld;

    spi_byte_rx u_byte_rx (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .lcd_cs    (lcd_cs),
        .lcd_dc    (lcd_dc),
        .lcd_sclk  (lcd_sclk),
        .lcd_mosi  (lcd_mosi),
        .rx_data   (w_rx_data),
        .rx_valid  (w_rx_valid),
        .err_abort (w_err_abort)
    );

    assign w_dc     = w_rx_data[8];
    assign w_byte   = w_rx_data[7:0];
    assign w_end    = COORD_W'({r_p_end, w_byte});
    assign w_x_wrap = (r_x == r_xe) || (r_x == ALL1);
    assign w_y_wrap = (r_y == r_ye) || (r_y == ALL1);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_rx_valid && !w_dc) begin
            case (w_byte)
                CMD_CASET: w_state_next = CASET;
                CMD_RASET: w_state_next = RASET;
                CMD_RAMWR: w_state_next = RAMWR;
                default:   w_state_next = IGNORE;
            endcase
        end
    end

    // Stage p2: decoded outputs aligned with rx_valid
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_data     <= 9'd0;
            rx_valid    <= 1'b0;
            cmd_valid   <= 1'b0;
            cmd_code    <= 8'd0;
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_rgb     <= 16'd0;
            frame_start <= 1'b0;
            err_abort   <= 1'b0;
            r_pidx      <= 3'd0;
            r_p_start   <= '0;
            r_p_end     <= '0;
            r_xs        <= '0;
            r_xe        <= XE_RST;
            r_ys        <= '0;
            r_ye        <= YE_RST;
            r_x         <= '0;
            r_y         <= '0;
            r_hi        <= 8'd0;
            r_hi_vld    <= 1'b0;
        end else begin
            rx_valid    <= w_rx_valid;
            cmd_valid   <= 1'b0;
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            err_abort   <= w_err_abort;
            if (w_rx_valid) begin
                rx_data <= w_rx_data;
                if (!w_dc) begin
                    cmd_valid <= 1'b1;
                    cmd_code  <= w_byte;
                    r_hi_vld  <= 1'b0;
                    r_pidx    <= 3'd0;
                    if (w_byte == CMD_RAMWR) begin
                        frame_start <= 1'b1;
                        r_x         <= r_xs;
                        r_y         <= r_ys;
                    end
                end else begin
                    case (r_state)
                        CASET, RASET: begin
                            if (r_pidx != 3'd4) begin
                                r_pidx <= r_pidx + 3'd1;
                            end
                            // Window only commits once the 4th parameter byte lands.
                            case (r_pidx)
                                3'd0: r_p_start <= COORD_W'(w_byte);
                                3'd1: r_p_start <= COORD_W'({r_p_start, w_byte});
                                3'd2: r_p_end   <= COORD_W'(w_byte);
                                3'd3: begin
                                    if (r_state == CASET) begin
                                        r_xs <= r_p_start;
                                        r_xe <= w_end;
                                    end else begin
                                        r_ys <= r_p_start;
                                        r_ye <= w_end;
                                    end
                                end
                                default: ;
                            endcase
                        end
                        RAMWR: begin
                            if (!r_hi_vld) begin
                                r_hi     <= w_byte;
                                r_hi_vld <= 1'b1;
                            end else begin
                                r_hi_vld  <= 1'b0;
                                pix_valid <= 1'b1;
                                pix_rgb   <= {r_hi, w_byte};
                                pix_x     <= r_x;
                                pix_y     <= r_y;
                                if (w_x_wrap) begin
                                    r_x <= r_xs;
                                    r_y <= w_y_wrap ? r_ys : r_y + 1'b1;
                                end else begin
                                    r_x <= r_x + 1'b1;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_st7735_spi_rx.sv
// Directed bench for st7735_spi_rx: drives SPI bytes and checks decoded strobes and pixels.
module tb_st7735_spi_rx;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        lcd_cs = 1'b1;
    logic        lcd_dc = 1'b0;
    logic        lcd_sclk = 1'b0;
    logic        lcd_mosi = 1'b0;
    logic [8:0]  rx_data;
    logic        rx_valid;
    logic        cmd_valid;
    logic [7:0]  cmd_code;
    logic        pix_valid;
    logic [7:0]  pix_x;
    logic [7:0]  pix_y;
    logic [15:0] pix_rgb;
    logic        frame_start;
    logic        err_abort;

    int n_assert = 0;
    int n_fail   = 0;

    int n_rx = 0, n_cmd = 0, n_pix = 0, n_fs = 0, n_err = 0, n_bad = 0;
    logic [8:0]  last_rx = '0;
    logic [7:0]  last_cmd = '0;
    logic [8:0]  last_cmd_rx = '0;
    logic [31:0] pix_q[$];

    st7735_spi_rx #(.WIDTH(128), .HEIGHT(160), .COORD_W(8)) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .lcd_cs      (lcd_cs),
        .lcd_dc      (lcd_dc),
        .lcd_sclk    (lcd_sclk),
        .lcd_mosi    (lcd_mosi),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .cmd_valid   (cmd_valid),
        .cmd_code    (cmd_code),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_rgb     (pix_rgb),
        .frame_start (frame_start),
        .err_abort   (err_abort)
    );

    always #5 sys_clk = ~sys_clk;

    // Event recorder, sampled on the inactive clock edge.
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (rx_valid) begin
                n_rx++;
                last_rx = rx_data;
            end
            if (cmd_valid) begin
                n_cmd++;
                last_cmd = cmd_code;
                last_cmd_rx = rx_data;
                if (!rx_valid) n_bad++;
            end
            if (pix_valid) begin
                n_pix++;
                pix_q.push_back({pix_x, pix_y, pix_rgb});
                if (!rx_valid) n_bad++;
            end
            if (frame_start) n_fs++;
            if (err_abort) n_err++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_pix(input string tag, input logic [7:0] x, input logic [7:0] y,
                           input logic [15:0] rgb);
        logic [31:0] got;
        got = 32'hxxxx_xxxx;
        if (pix_q.size() != 0) got = pix_q.pop_front();
        chk(tag, got, {x, y, rgb});
    endtask

    task automatic spi_bits(input logic dc, input logic [7:0] b, input int n);
        lcd_dc = dc;
        for (int i = 0; i < n; i++) begin
            lcd_mosi = b[7-i];
            #40 lcd_sclk = 1'b1;
            #40 lcd_sclk = 1'b0;
        end
    endtask

    task automatic send(input logic dc, input logic [7:0] b);
        spi_bits(dc, b, 8);
    endtask

    task automatic send_pix(input logic [15:0] p);
        send(1'b1, p[15:8]);
        send(1'b1, p[7:0]);
    endtask

    task automatic settle();
        repeat (12) @(posedge sys_clk);
        #2;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_strobes"}, {27'd0, rx_valid, cmd_valid, pix_valid, frame_start, err_abort}, 32'd0);
        chk({tag, "_rx_data"}, {23'd0, rx_data}, 32'd0);
        chk({tag, "_cmd_code"}, {24'd0, cmd_code}, 32'd0);
        chk({tag, "_pix"}, {pix_x, pix_y, pix_rgb}, 32'd0);
    endtask

    initial begin
        logic [31:0] drop;

        // Power-on reset
        repeat (5) @(posedge sys_clk);
        #2;
        chk_outputs_zero("por");
        sys_rst_n = 1'b1;
        repeat (3) @(posedge sys_clk);
        lcd_cs = 1'b0;
        #40;

        // Generic command followed by a data byte
        send(1'b0, 8'h11);
        settle();
        chk("cmd11_count", n_cmd, 1);
        chk("cmd11_code", {24'd0, last_cmd}, 32'h11);
        chk("cmd11_rx_data", {23'd0, last_cmd_rx}, 32'h011);
        send(1'b1, 8'hA5);
        settle();
        chk("dataA5_rx_count", n_rx, 2);
        chk("dataA5_rx_data", {23'd0, last_rx}, 32'h1A5);
        chk("dataA5_no_pix", n_pix, 0);

        // Final sclk edge coincident with cs release: byte completes, no abort
        spi_bits(1'b1, 8'h3C, 7);
        lcd_mosi = 1'b0;
        #40;
        lcd_sclk = 1'b1;
        lcd_cs   = 1'b1;
        #40 lcd_sclk = 1'b0;
        settle();
        chk("simul_rx_count", n_rx, 3);
        chk("simul_rx_data", {23'd0, last_rx}, 32'h13C);
        chk("simul_no_abort", n_err, 0);
        lcd_cs = 1'b0;
        #40;

        // 2x2 window and RAMWR stream with wrap back to the origin
        send(1'b0, 8'h2A); send(1'b1, 8'h00); send(1'b1, 8'h02); send(1'b1, 8'h00); send(1'b1, 8'h03);
        send(1'b0, 8'h2B); send(1'b1, 8'h00); send(1'b1, 8'h05); send(1'b1, 8'h00); send(1'b1, 8'h06);
        send(1'b0, 8'h2C);
        send_pix(16'hF800); send_pix(16'h07E0); send_pix(16'h001F); send_pix(16'hFFFF); send_pix(16'h1234);
        settle();
        chk("win_frame_start", n_fs, 1);
        chk("win_pix_count", n_pix, 5);
        chk_pix("win_pix0", 8'd2, 8'd5, 16'hF800);
        chk_pix("win_pix1", 8'd3, 8'd5, 16'h07E0);
        chk_pix("win_pix2", 8'd2, 8'd6, 16'h001F);
        chk_pix("win_pix3", 8'd3, 8'd6, 16'hFFFF);
        chk_pix("win_pix4_wrap", 8'd2, 8'd5, 16'h1234);
        chk("win_rx_count", n_rx, 24);

        // Partial byte aborted by cs release
        spi_bits(1'b1, 8'hFF, 5);
        #40 lcd_cs = 1'b1;
        settle();
        chk("abort_count", n_err, 1);
        chk("abort_no_rx", n_rx, 24);
        lcd_cs = 1'b0;
        #40;
        send(1'b0, 8'h2C);
        settle();
        chk("post_abort_cmd", {24'd0, last_cmd}, 32'h2C);
        chk("post_abort_rx_data", {23'd0, last_cmd_rx}, 32'h02C);
        chk("post_abort_fs", n_fs, 2);
        chk("post_abort_abort_once", n_err, 1);

        // Asynchronous reset mid-RAMWR and mid-byte
        send(1'b1, 8'h12);
        spi_bits(1'b1, 8'h80, 3);
        #13 sys_rst_n = 1'b0;
        #3;
        chk_outputs_zero("rst_async");
        lcd_cs = 1'b1;
        repeat (4) @(posedge sys_clk);
        #2 sys_rst_n = 1'b1;
        repeat (3) @(posedge sys_clk);
        lcd_cs = 1'b0;
        #40;

        // RAMWR with odd byte count then a command; window is back at reset values
        send(1'b0, 8'h2C);
        settle();
        chk("rst_next_cmd", {24'd0, last_cmd_rx}, 32'h02C);
        send(1'b1, 8'hAB); send(1'b1, 8'hCD); send(1'b1, 8'hEF);
        send(1'b0, 8'h00);
        settle();
        chk_pix("odd_pix0", 8'd0, 8'd0, 16'hABCD);
        chk("odd_pix_count", n_pix, 6);
        chk("odd_cmd00", {24'd0, last_cmd}, 32'h00);

        // Truncated CASET leaves the full-width window in place
        send(1'b0, 8'h2A); send(1'b1, 8'h00); send(1'b1, 8'h05);
        send(1'b0, 8'h2C);
        send_pix(16'h5555);
        for (int i = 1; i < 129; i++) send_pix(16'(i));
        settle();
        chk("trunc_pix_count", n_pix, 135);
        chk_pix("trunc_pix0", 8'd0, 8'd0, 16'h5555);
        for (int i = 1; i < 127; i++) drop = pix_q.pop_front();
        chk_pix("trunc_pix127_xe", 8'd127, 8'd0, 16'd127);
        chk_pix("trunc_pix128_row1", 8'd0, 8'd1, 16'd128);

        // Column end truncated to 0 so only the all-ones rule wraps x
        send(1'b0, 8'h2A); send(1'b1, 8'h00); send(1'b1, 8'hFD); send(1'b1, 8'h01); send(1'b1, 8'h00);
        send(1'b0, 8'h2B); send(1'b1, 8'h00); send(1'b1, 8'h07); send(1'b1, 8'h00); send(1'b1, 8'h07);
        send(1'b0, 8'h2C);
        for (int i = 0; i < 4; i++) send_pix(16'hA000 + 16'(i));
        settle();
        chk_pix("ones_pix0", 8'hFD, 8'd7, 16'hA000);
        chk_pix("ones_pix1", 8'hFE, 8'd7, 16'hA001);
        chk_pix("ones_pix2", 8'hFF, 8'd7, 16'hA002);
        chk_pix("ones_pix3_wrap", 8'hFD, 8'd7, 16'hA003);
        chk("ones_fs", n_fs, 5);

        chk("final_abort_total", n_err, 1);
        chk("strobe_alignment", n_bad, 0);
        chk("queue_drained", pix_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
